// File: rtl/instruction_memory_loader_if.sv
// Fetch and byte-loader bus for instruction_memory_loader.
// Optional macro IMEM_PARITY_EN adds the fetch_parity_err signal.
interface instruction_memory_loader_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [PC_WIDTH-1:0]   fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_fault;
`ifdef IMEM_PARITY_EN
    logic                  fetch_parity_err;
`endif
    logic                  load_start;
    logic [PC_WIDTH-1:0]   load_base;
    logic                  load_byte_valid;
    logic [7:0]            load_byte;
    logic                  load_end;
    logic                  load_busy;
    logic [PC_WIDTH-1:0]   load_words;
    logic                  load_overflow;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
`ifdef IMEM_PARITY_EN
        input  fetch_parity_err,
`endif
        output load_start, load_base, load_byte_valid, load_byte, load_end,
        input  load_busy, load_words, load_overflow
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault,
`ifdef IMEM_PARITY_EN
        output fetch_parity_err,
`endif
        input  load_start, load_base, load_byte_valid, load_byte, load_end,
        output load_busy, load_words, load_overflow
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction store with registered fetch port and byte-serial little-endian program loader.
// Optional macro IMEM_PARITY_EN: per-word even parity stored on load, checked on fetch.
module instruction_memory_loader #(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32
) (
    input logic                         clk,
    input logic                         rst_n,
    instruction_memory_loader_if.slave  io_bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [0:0] {LdIdle, LdActive} ld_state_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    ld_state_e             r_state;
    logic [AW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_asm;
    logic [PC_WIDTH-1:0]   r_words;
    logic                  r_overflow;

    logic                  r_fetch_valid;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic                  r_fetch_fault;

    logic                  w_fetch_accept;
    logic [PC_WIDTH-1:0]   w_fetch_word;
    logic                  w_fetch_fault;
    logic [AW-1:0]         w_fetch_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_asm_next;
    logic                  w_word_full;
    logic                  w_has_partial;
    logic                  w_session;
    logic                  w_we;
    logic                  w_ptr_in_range;
    logic                  w_ptr_last;
    logic                  w_unused_base;

    assign w_unused_base = ^{io_bus.load_base[1:0], io_bus.load_base[PC_WIDTH-1:AW+2]};

    // Fetch side: the loader owns the RAM for the whole session.
    assign w_fetch_accept = io_bus.fetch_req && (r_state == LdIdle);
    assign w_fetch_word   = io_bus.fetch_addr >> 2;
    assign w_fetch_fault  = (io_bus.fetch_addr[1:0] != 2'b00) ||
                            (w_fetch_word >= PC_WIDTH'(DEPTH));
    assign w_fetch_idx    = w_fetch_word[AW-1:0];
    assign w_rd_data      = r_mem[w_fetch_idx];

    always_comb begin
        w_asm_next = r_asm;
        if (io_bus.load_byte_valid) begin
            for (int i = 0; i < BYTES; i++) begin
                if (r_cnt == CW'(i)) w_asm_next[8*i +: 8] = io_bus.load_byte;
            end
        end
    end

    assign w_word_full    = io_bus.load_byte_valid && (r_cnt == CW'(BYTES - 1));
    assign w_has_partial  = (r_cnt != '0) || io_bus.load_byte_valid;
    assign w_session      = (r_state == LdActive) && !io_bus.load_start;
    assign w_we           = w_session && (w_word_full || (io_bus.load_end && w_has_partial));
    // A truncated load_base can point past DEPTH-1 when DEPTH is not a power of two.
    assign w_ptr_in_range = {1'b0, r_ptr} <  (AW+1)'(DEPTH);
    assign w_ptr_last     = {1'b0, r_ptr} >= (AW+1)'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (w_we && w_ptr_in_range) r_mem[r_ptr] <= w_asm_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LdIdle;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_asm      <= '0;
            r_words    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                LdIdle: begin
                    if (io_bus.load_start) begin
                        r_state    <= LdActive;
                        r_ptr      <= io_bus.load_base[AW+1:2];
                        r_cnt      <= '0;
                        r_asm      <= '0;
                        r_words    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                LdActive: begin
                    if (io_bus.load_start) begin
                        r_ptr      <= io_bus.load_base[AW+1:2];
                        r_cnt      <= '0;
                        r_asm      <= '0;
                        r_words    <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (w_we) begin
                            r_words <= r_words + PC_WIDTH'(1);
                            if (w_ptr_last) begin
                                r_ptr      <= '0;
                                r_overflow <= 1'b1;
                            end else begin
                                r_ptr <= r_ptr + AW'(1);
                            end
                        end
                        // Assembly register is cleared after every commit so upper lanes pad with zero.
                        if (w_we || io_bus.load_end) begin
                            r_cnt <= '0;
                            r_asm <= '0;
                        end else if (io_bus.load_byte_valid) begin
                            r_cnt <= r_cnt + CW'(1);
                            r_asm <= w_asm_next;
                        end
                        if (io_bus.load_end) r_state <= LdIdle;
                    end
                end
                default: r_state <= LdIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_fetch_fault <= w_fetch_fault;
                r_fetch_data  <= w_fetch_fault ? '0 : w_rd_data;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (w_we && w_ptr_in_range) r_par[r_ptr] <= ^w_asm_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_fetch_accept && !w_fetch_fault &&
                            ((^w_rd_data) != r_par[w_fetch_idx]);
        end
    end

    assign io_bus.fetch_parity_err = r_parity_err;
`endif

    assign io_bus.fetch_ready   = (r_state == LdIdle);
    assign io_bus.load_busy     = (r_state == LdActive);
    assign io_bus.fetch_valid   = r_fetch_valid;
    assign io_bus.fetch_data    = r_fetch_data;
    assign io_bus.fetch_fault   = r_fetch_fault;
    assign io_bus.load_words    = r_words;
    assign io_bus.load_overflow = r_overflow;

endmodule
